life_engine: RTL and testbench

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/life_engine.sv | 158 +++++++++++++++
 tb/tb_life_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Conway's Game of Life engine for an 8x8 board.
//
// The current generation lives in `grid` and feeds the display scanner. A
// `step` request in IDLE starts a scan. The scan evaluates one cell per cycle
// into a shadow `next` buffer while `grid` holds still. A single COMMIT cycle
// then copies `next` into `grid` in one edge, so the display never sees a
// half-updated board.
//
// Parameters
//   WRAP       1: toroidal board (edges wrap). 0: off-board cells count as dead.
//   SEED       board value loaded by reset.
//
// Ports
//   clk        system clock; all state updates on posedge
//   _rst       asynchronous active-low reset
//   step       request one generation (sampled in IDLE only)
//   load       write load_data into grid row load_row (IDLE only; wins over step)
//   load_row   row index for load
//   load_data  row contents for load; bit c = column c
//   grid       current generation; bit 8r+c = cell (r,c)
//   busy       high while a generation is being computed (state != IDLE)
//   done       one-cycle pulse in the cycle after a generation is committed
//   gen_count  committed generations since reset (wraps at 16 bits)
module life_engine #(
    parameter bit          WRAP = 1'b1,
    parameter logic [63:0] SEED = 64'h0000_0000_0007_0402
) (
    input  logic        clk,
    input  logic        _rst,
    input  logic        step,
    input  logic        load,
    input  logic [2:0]  load_row,
    input  logic [7:0]  load_data,
    output logic [63:0] grid,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCommit
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] grid_q, grid_d;
    logic [63:0] next_q, next_d;
    logic [5:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic [15:0] gen_q, gen_d;

    logic [2:0]  cur_row;
    logic [2:0]  cur_col;
    logic [3:0]  n_count;
    logic        alive;
    logic        cell_next;

    // Value of cell (r,c) of board g. Coordinates arrive as signed ints so a
    // step off either edge is visible. Taking the low three bits of a two's
    // complement value is exactly modulo 8, which gives the toroidal wrap.
    function automatic logic cell_at(input logic [63:0] g, input int r, input int c);
        logic v;
        v = 1'b0;
        if (WRAP) begin
            v = g[{r[2:0], c[2:0]}];
        end else if (r >= 0 && r <= 7 && c >= 0 && c <= 7) begin
            v = g[{r[2:0], c[2:0]}];
        end
        return v;
    endfunction

    assign cur_row = idx_q[5:3];
    assign cur_col = idx_q[2:0];
    assign alive   = grid_q[idx_q];

    // Live-neighbour count of the cell under the scan index, over the 3x3
    // window minus the centre.
    always_comb begin
        n_count = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    n_count = n_count +
                              {3'b000, cell_at(grid_q, int'(cur_row) + dr, int'(cur_col) + dc)};
                end
            end
        end
    end

    assign cell_next = (n_count == 4'd3) | (alive & (n_count == 4'd2));

    // Next-state logic. Every register holds its value by default; done is a
    // pulse and defaults low.
    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        next_d  = next_q;
        idx_d   = idx_q;
        gen_d   = gen_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A load takes the edge; a step arriving with it is dropped.
                if (load) begin
                    grid_d[{load_row, 3'b000} +: 8] = load_data;
                end else if (step) begin
                    state_d = StScan;
                    idx_d   = 6'd0;
                end
            end
            StScan: begin
                // All 64 cells are rewritten every scan, so next needs no
                // clearing between generations.
                next_d[idx_q] = cell_next;
                idx_d         = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                grid_d  = next_q;
                gen_d   = gen_q + 16'd1;
                done_d  = 1'b1;
                idx_d   = 6'd0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= StIdle;
            grid_q  <= SEED;
            next_q  <= '0;
            idx_q   <= '0;
            gen_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            next_q  <= next_d;
            idx_q   <= idx_d;
            gen_q   <= gen_d;
            done_q  <= done_d;
        end
    end

    assign grid      = grid_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine. Two instances share the stimulus: `dut` is
// the default toroidal engine and `dut_nw` the non-wrapping variant. Inputs
// change right after a falling edge and outputs are sampled on falling edges.
module tb_life_engine;

    localparam logic [63:0] SEED      = 64'h0000_0000_0007_0402;
    localparam logic [63:0] BLINK_H   = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V   = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK     = 64'h0000_0018_1800_0000;
    localparam logic [63:0] EDGE_WRAP = 64'h0100_0000_0000_0101;
    localparam logic [63:0] GLIDER_1  = 64'h0000_0000_0206_0500;

    logic        clk;
    logic        rst;
    logic        step;
    logic        load;
    logic [2:0]  load_row;
    logic [7:0]  load_data;
    logic [63:0] grid, grid_nw;
    logic        busy, busy_nw;
    logic        done, done_nw;
    logic [15:0] gen_count, gen_count_nw;

    int n_cmp;
    int n_bad;
    int exp_gen;

    life_engine #(.WRAP(1'b1)) dut (
        .clk       (clk),
        ._rst      (rst),
        .step      (step),
        .load      (load),
        .load_row  (load_row),
        .load_data (load_data),
        .grid      (grid),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    life_engine #(.WRAP(1'b0)) dut_nw (
        .clk       (clk),
        ._rst      (rst),
        .step      (step),
        .load      (load),
        .load_row  (load_row),
        .load_data (load_data),
        .grid      (grid_nw),
        .busy      (busy_nw),
        .done      (done_nw),
        .gen_count (gen_count_nw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers; each starts and ends just after a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b0;
        step = 1'b0;
        load = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        exp_gen = 0;
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] d);
        load      = 1'b1;
        load_row  = r;
        load_data = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic clear_grid();
        for (int i = 0; i < 8; i++) write_row(3'(i), 8'h00);
    endtask

    // Issue one step and return how many sampled cycles busy was high; it
    // returns in the first cycle with busy low (the done cycle).
    task automatic run_step(output int busy_cycles);
        step = 1'b1;
        @(negedge clk);
        step        = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (grid !== SEED) begin n_bad++; $display("FAIL reset_grid: got %h want %h", grid, SEED); end
        n_cmp++; if (grid_nw !== SEED) begin n_bad++; $display("FAIL reset_grid_nw: got %h want %h", grid_nw, SEED); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (gen_count !== 16'd0) begin n_bad++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
    endtask

    task automatic test_blinker();
        int bc;
        clear_grid();
        write_row(3'd3, 8'h1C);
        n_cmp++; if (grid !== BLINK_H) begin n_bad++; $display("FAIL blinker_load: got %h want %h", grid, BLINK_H); end
        run_step(bc);
        exp_gen++;
        n_cmp++; if (bc !== 65) begin n_bad++; $display("FAIL blinker_busy_len: got %0d want 65", bc); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL blinker_done: got %b want 1", done); end
        n_cmp++; if (grid !== BLINK_V) begin n_bad++; $display("FAIL blinker_gen1: got %h want %h", grid, BLINK_V); end
        n_cmp++; if (gen_count !== 16'(exp_gen)) begin n_bad++; $display("FAIL blinker_gen_count1: got %0d want %0d", gen_count, exp_gen); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL blinker_done_pulse: got %b want 0", done); end
        run_step(bc);
        exp_gen++;
        n_cmp++; if (grid !== BLINK_H) begin n_bad++; $display("FAIL blinker_gen2: got %h want %h", grid, BLINK_H); end
        n_cmp++; if (gen_count !== 16'(exp_gen)) begin n_bad++; $display("FAIL blinker_gen_count2: got %0d want %0d", gen_count, exp_gen); end
    endtask

    task automatic test_block();
        int bc;
        clear_grid();
        write_row(3'd3, 8'h18);
        write_row(3'd4, 8'h18);
        run_step(bc);
        exp_gen++;
        n_cmp++; if (grid !== BLOCK) begin n_bad++; $display("FAIL block_still: got %h want %h", grid, BLOCK); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL block_done: got %b want 1", done); end
        n_cmp++; if (gen_count !== 16'(exp_gen)) begin n_bad++; $display("FAIL block_gen_count: got %0d want %0d", gen_count, exp_gen); end
    endtask

    task automatic test_wrap();
        int bc;
        clear_grid();
        write_row(3'd0, 8'h83);
        run_step(bc);
        exp_gen++;
        n_cmp++; if (grid !== EDGE_WRAP) begin n_bad++; $display("FAIL wrap_torus: got %h want %h", grid, EDGE_WRAP); end
        n_cmp++; if (grid_nw !== 64'd0) begin n_bad++; $display("FAIL wrap_flat: got %h want 0", grid_nw); end
    endtask

    task automatic test_busy_ignore();
        int busy_cnt;
        int done_cnt;
        clear_grid();
        write_row(3'd3, 8'h1C);
        step = 1'b1;
        @(negedge clk);
        step     = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (i >= 10 && i <= 12) begin
                step      = 1'b1;
                load      = 1'b1;
                load_row  = 3'd0;
                load_data = 8'hFF;
            end else begin
                step = 1'b0;
                load = 1'b0;
            end
            @(negedge clk);
        end
        exp_gen++;
        n_cmp++; if (busy_cnt !== 65) begin n_bad++; $display("FAIL ignore_busy_len: got %0d want 65", busy_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (grid !== BLINK_V) begin n_bad++; $display("FAIL ignore_result: got %h want %h", grid, BLINK_V); end
        n_cmp++; if (gen_count !== 16'(exp_gen)) begin n_bad++; $display("FAIL ignore_gen_count: got %0d want %0d", gen_count, exp_gen); end
    endtask

    task automatic test_load_step_idle();
        int busy_seen;
        load      = 1'b1;
        step      = 1'b1;
        load_row  = 3'd5;
        load_data = 8'h81;
        @(negedge clk);
        load = 1'b0;
        step = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0) busy_seen++;
            @(negedge clk);
        end
        n_cmp++; if (grid !== 64'h0000_8108_0808_0000) begin
            n_bad++; $display("FAIL load_step_row: got %h want %h", grid, 64'h0000_8108_0808_0000);
        end
        n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL load_step_busy: got %0d busy cycles want 0", busy_seen); end
    endtask

    task automatic test_reset_mid_scan();
        int bc;
        int done_cnt;
        clear_grid();
        write_row(3'd3, 8'h1C);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (29) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midscan_busy: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        exp_gen = 0;
        n_cmp++; if (grid !== SEED) begin n_bad++; $display("FAIL midscan_reset_grid: got %h want %h", grid, SEED); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midscan_reset_busy: got %b want 0", busy); end
        n_cmp++; if (gen_count !== 16'd0) begin n_bad++; $display("FAIL midscan_reset_gen: got %0d want 0", gen_count); end
        @(negedge clk);
        rst      = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (done !== 1'b0) done_cnt++;
            @(negedge clk);
        end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midscan_no_done: got %0d want 0", done_cnt); end
        n_cmp++; if (grid !== SEED) begin n_bad++; $display("FAIL midscan_grid_held: got %h want %h", grid, SEED); end
        run_step(bc);
        exp_gen++;
        n_cmp++; if (grid !== GLIDER_1) begin n_bad++; $display("FAIL glider_gen1: got %h want %h", grid, GLIDER_1); end
        n_cmp++; if (gen_count !== 16'(exp_gen)) begin n_bad++; $display("FAIL glider_gen_count: got %0d want %0d", gen_count, exp_gen); end
        n_cmp++; if (bc !== 65) begin n_bad++; $display("FAIL glider_busy_len: got %0d want 65", bc); end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int first_at;
        int second_at;
        int guard;
        clear_grid();
        write_row(3'd3, 8'h1C);
        step      = 1'b1;
        done_cnt  = 0;
        first_at  = -1;
        second_at = -1;
        @(negedge clk);
        for (int i = 0; i < 140; i++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (first_at < 0) first_at = i;
                else if (second_at < 0) second_at = i;
            end
            @(negedge clk);
        end
        step = 1'b0;
        exp_gen += 2;
        n_cmp++; if (done_cnt !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
        n_cmp++; if (first_at !== 65) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 65", first_at); end
        n_cmp++; if (second_at - first_at !== 66) begin
            n_bad++; $display("FAIL b2b_period: got %0d want 66", second_at - first_at);
        end
        n_cmp++; if (grid !== BLINK_H) begin n_bad++; $display("FAIL b2b_grid: got %h want %h", grid, BLINK_H); end
        n_cmp++; if (gen_count !== 16'(exp_gen)) begin n_bad++; $display("FAIL b2b_gen_count: got %0d want %0d", gen_count, exp_gen); end
        // A third generation was started by the held step; let it drain.
        guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: busy got %b want 0", busy); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_gen   = 0;
        rst       = 1'b0;
        step      = 1'b0;
        load      = 1'b0;
        load_row  = 3'd0;
        load_data = 8'h00;
        test_reset();
        test_blinker();
        test_block();
        test_wrap();
        test_busy_ignore();
        test_load_step_idle();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
